// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fwd_scoreboard : EX-stage forwarding select and load-use hazard detection
//                  over a DEPTH-entry tracker of in-flight register writers.
// Revision 1.0
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold_i,
    input  logic                        ex_valid_i,
    input  logic                        ex_RegWrite_i,
    input  logic                        ex_MemRead_i,
    input  logic [ADDR_W-1:0]           ex_RegWriteAddr_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_SrcAddr_i,
    input  logic [NUM_SRC-1:0]          ex_SrcUsed_i,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
    output logic                        stall_o,
    output logic [CNT_W-1:0]            stall_cnt_o,
    input  logic                        clr_cnt_i
);

    typedef struct packed {
        logic              v;
        logic              wr;
        logic              ld;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    localparam logic [SEL_W-1:0] LR_SEL = SEL_W'(LOAD_READY);

    entry_t             trk_q [1:DEPTH];
    entry_t             trk_d [1:DEPTH];
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [NUM_SRC-1:0] haz;
    logic               stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [ADDR_W-1:0] src;
        logic [SEL_W-1:0]  win_k;
        logic              win_ld;

        assign src = ex_SrcAddr_i[i*ADDR_W +: ADDR_W];

        // Scan oldest to youngest so the youngest match overwrites the rest.
        always_comb begin
            win_k  = '0;
            win_ld = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (trk_q[k].v && trk_q[k].wr && (trk_q[k].addr == src) &&
                    (src != '0) && ex_SrcUsed_i[i] && ex_valid_i) begin
                    win_k  = SEL_W'(k);
                    win_ld = trk_q[k].ld;
                end
            end
        end

        assign haz[i] = win_ld && (win_k < LR_SEL);
        assign fwd_sel_o[i*SEL_W +: SEL_W] = haz[i] ? '0 : win_k;
    end

    assign stall       = (|haz) && ex_valid_i && !hold_i;
    assign stall_o     = stall;
    assign stall_cnt_o = cnt_q;

    always_comb begin
        for (int k = DEPTH; k >= 2; k--) begin
            trk_d[k] = trk_q[k-1];
        end
        // A stalled EX instruction stays put, so a bubble enters the tracker.
        trk_d[1] = stall ? '0 : entry_t'({ex_valid_i, ex_RegWrite_i,
                                          ex_MemRead_i, ex_RegWriteAddr_i});
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                trk_q[k] <= '0;
            end
            cnt_q <= '0;
        end else if (!hold_i) begin
            trk_q <= trk_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the EX stage of the pipelined MIPS core.
- Tracks in-flight register writers in an internal DEPTH-entry shift register (entry 1 = MEM, entry 2 = WB, entries 3..DEPTH = extra late stages).
- For each of NUM_SRC EX-stage source operands, selects the youngest matching producer as the forwarding source.
- Raises a load-use stall when that producer's load data is not yet available, and counts stall cycles.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 2, number of EX source operands (2 = Rs/Rt; 3 supported for store/FMA paths).
- DEPTH, 2, number of tracked downstream stages (1..7).
- LOAD_READY, 2, first tracker entry at which load data may be forwarded (1..DEPTH).
- SEL_W, 3, select width; must satisfy 2^SEL_W > DEPTH.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  global pipeline freeze (e.g. cache miss); tracker and counter hold.
- ex_valid  in  1  EX holds a real instruction (0 = bubble/flushed).
- ex_RegWrite  in  1  EX instruction writes a register.
- ex_MemRead  in  1  EX instruction is a load.
- ex_RegWriteAddr  in  ADDR_W  EX destination.
- ex_SrcAddr  in  NUM_SRC*ADDR_W  source addresses; operand i at bits [i*ADDR_W +: ADDR_W].
- ex_SrcUsed  in  NUM_SRC  per-operand "actually read" flag.
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = tracker entry k.
- stall  out  1  hold EX, insert bubble downstream.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- clr_cnt  in  1  synchronous clear of stall_cnt.

Behaviour:
- Tracker entry k holds {v, wr, ld, addr}.
- Reset (async, rst=1): all entries v=0 and stall_cnt=0. Outputs are therefore immediately fwd_sel=0 and stall=0 (combinational from the cleared state).
- Match for operand i at entry k: v & wr & addr==src_i & src_i!=0 & ex_SrcUsed[i] & ex_valid.
- Priority: lowest k wins (youngest producer). Older matches are ignored even if they are ready.
- Hazard on operand i: the winning entry has ld=1 and k<LOAD_READY. This forces fwd_sel_i=0 and contributes to stall.
- Otherwise fwd_sel_i = winning k, or 0 if there is no match.
- stall = OR of the per-operand hazards; it is forced to 0 when ex_valid=0 or hold=1.
- All outputs are combinational from tracker state and ex_* inputs, with zero-cycle latency.
- Clock edge, hold=1: tracker and stall_cnt are unchanged.
- Clock edge, hold=0, stall=0:
  - entries k+1 <= k for k = 1..DEPTH-1; the oldest entry is dropped;
  - entry 1 <= {ex_valid, ex_RegWrite, ex_MemRead, ex_RegWriteAddr}.
- Clock edge, hold=0, stall=1: entries shift as above, but entry 1 <= bubble (v=0). Because the EX instruction is held, the next cycle re-evaluates with the producer one stage older.
- stall_cnt:
  - increments on each clock with hold=0 & stall=1;
  - saturates at all-ones with no wrap;
  - clr_cnt has priority over increment.
- Address 0: never forwarded and never stalls, even if a writer targets r0.
- Multiple operands may select different entries in the same cycle, and they may select the same entry.
- DEPTH=2, LOAD_READY=2, NUM_SRC=2 must reproduce classic MEM/WB forwarding: select 1 = EX/MEM, 2 = MEM/WB, and a 1-cycle load-use stall.
- A load at entry k>=LOAD_READY forwards normally.
- With LOAD_READY=3, a dependent instruction stalls 2 consecutive cycles when immediately behind a load.
- rst asserted mid-stall: stall drops in the same cycle and the tracker is empty afterwards.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, ex_valid=0 → fwd_sel=0, stall=0, stall_cnt=0.
- ALU chain: add r3 in EX, then consumer with src0=r3 next cycle → fwd_sel[0]=1. Two cycles later (one unrelated instruction between) → fwd_sel[0]=2.
- Youngest wins: r5 is written at entries 1 and 2; consumer reads r5 on both operands → both fwd_sel=1. Consumer reads r0 with writers to r0 in flight → fwd_sel=0.
- Load-use (DEPTH=2, LOAD_READY=2): lw r4, then consumer src1=r4:
  - cycle 1: stall=1, fwd_sel[1]=0;
  - cycle 2: stall=0, fwd_sel[1]=2;
  - stall_cnt=1.
- Parametric (DEPTH=4, LOAD_READY=3, NUM_SRC=3): lw r7, then consumer src2=r7 → stall for exactly 2 cycles, then fwd_sel[2]=3, stall_cnt=2.
- Hold/saturation:
  - hold=1 during a pending hazard → stall=0, tracker frozen; on release, stall resumes.
  - preload stall_cnt at all-ones (CNT_W=4: 15 stalls), one more stall → stays 15; clr_cnt → 0.
